// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and defaults for the decode-stage issue controller.
// Holds opcodes, default latencies, FSM state enum and register index type.
package decode_issue_ctrl_pkg;

    localparam int DEF_NUM_REGS  = 16;
    localparam int DEF_LAT_W     = 3;
    localparam int DEF_ALU_LAT   = 2;
    localparam int DEF_LOAD_LAT  = 4;
    localparam int DEF_FLUSH_CYC = 2;
    localparam int FCNT_W        = 4;

    localparam logic [4:0] OPC_NOP  = 5'h00;
    localparam logic [4:0] OPC_LOAD = 5'h10;

    typedef logic [3:0] reg_idx_t;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/decode_issue_ctrl_issue_scoreboard.sv
// Per-register countdown scoreboard for in-flight results.
// Three lookup ports report the current (pre-decrement) count.
module issue_scoreboard
    import decode_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int LAT_W    = DEF_LAT_W
) (
    input  logic             clk_r,
    input  logic             reset_n_r,
    input  logic             load_en,
    input  reg_idx_t         load_idx,
    input  logic [LAT_W-1:0] load_lat,
    input  reg_idx_t         s1_idx,
    input  reg_idx_t         s2_idx,
    input  reg_idx_t         dest_idx,
    output logic [LAT_W-1:0] s1_cnt,
    output logic [LAT_W-1:0] s2_cnt,
    output logic [LAT_W-1:0] dest_cnt,
    output logic             busy
);

    logic [LAT_W-1:0] cnt     [NUM_REGS];
    logic [LAT_W-1:0] cnt_nxt [NUM_REGS];
    logic             any_nxt;

    assign s1_cnt   = cnt[s1_idx];
    assign s2_cnt   = cnt[s2_idx];
    assign dest_cnt = cnt[dest_idx];

    // Saturating decrement of every counter; a new issue load overrides it.
    always_comb begin
        any_nxt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_nxt[r] = (|cnt[r]) ? cnt[r] - LAT_W'(1) : '0;
            if (load_en && (load_idx == reg_idx_t'(r))) begin
                cnt_nxt[r] = load_lat;
            end
            any_nxt = any_nxt | (|cnt_nxt[r]);
        end
    end

    // Counter array and registered busy flag.
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            busy <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            busy <= any_nxt;
        end
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage issue controller: scoreboard hazard check, bubbles, flush window.
// Optional stall counter enabled by DECODE_ISSUE_STALL_CNT_EN.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int         NUM_REGS  = DEF_NUM_REGS,
    parameter int         LAT_W     = DEF_LAT_W,
    parameter int         ALU_LAT   = DEF_ALU_LAT,
    parameter int         LOAD_LAT  = DEF_LOAD_LAT,
    parameter logic [4:0] LOAD_OPC  = OPC_LOAD,
    parameter int         FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic        clk_r,
    input  logic        reset_n_r,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  opcode_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  s1_in,
    input  logic [3:0]  s2_in,
    input  logic [1:0]  src_use_in,
    input  logic        wr_en_in,
    input  logic        flush_in,
    output logic        issue_valid,
    output logic [4:0]  opcode_out,
    output logic [3:0]  dest_out,
    output logic [3:0]  s1_out,
    output logic [3:0]  s2_out,
    output logic        stall_out,
    output logic        sb_busy,
    output logic [15:0] stall_cnt
);

    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYC - 1);

    state_e            state;
    logic [FCNT_W-1:0] fcnt;

    logic [LAT_W-1:0]  lat;
    logic [LAT_W-1:0]  s1_cnt;
    logic [LAT_W-1:0]  s2_cnt;
    logic [LAT_W-1:0]  dest_cnt;
    logic              raw;
    logic              waw;
    logic              hazard;
    logic              run;
    logic              issue;

    issue_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .LAT_W    (LAT_W)
    ) u_sb (
        .clk_r     (clk_r),
        .reset_n_r (reset_n_r),
        .load_en   (issue & wr_en_in),
        .load_idx  (dest_in),
        .load_lat  (lat),
        .s1_idx    (s1_in),
        .s2_idx    (s2_in),
        .dest_idx  (dest_in),
        .s1_cnt    (s1_cnt),
        .s2_cnt    (s2_cnt),
        .dest_cnt  (dest_cnt),
        .busy      (sb_busy)
    );

    // Hazard detection against the current scoreboard and handshake.
    always_comb begin
        lat = (opcode_in == LOAD_OPC) ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
        raw = (src_use_in[0] & (|s1_cnt)) | (src_use_in[1] & (|s2_cnt));
        waw = wr_en_in & (dest_cnt > lat);
        hazard = raw | waw;
        run = (state == ST_RUN);
        in_ready = run ? (~hazard & ~flush_in) : 1'b1;
        issue = run & in_valid & in_ready;
        stall_out = run & in_valid & ~in_ready;
    end

    // RUN/FLUSH sequencing; flush_in inside the window restarts it.
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (flush_in) begin
                        state <= ST_FLUSH;
                        fcnt  <= FCNT_RELOAD;
                    end
                end
                ST_FLUSH: begin
                    if (flush_in) begin
                        fcnt <= FCNT_RELOAD;
                    end else if (fcnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RUN;
                    fcnt  <= '0;
                end
            endcase
        end
    end

    // Decode register: issued fields, or an all-zero NOP bubble.
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            issue_valid <= 1'b0;
            opcode_out  <= OPC_NOP;
            dest_out    <= '0;
            s1_out      <= '0;
            s2_out      <= '0;
        end else if (issue) begin
            issue_valid <= 1'b1;
            opcode_out  <= opcode_in;
            dest_out    <= dest_in;
            s1_out      <= s1_in;
            s2_out      <= s2_in;
        end else begin
            issue_valid <= 1'b0;
            opcode_out  <= OPC_NOP;
            dest_out    <= '0;
            s1_out      <= '0;
            s2_out      <= '0;
        end
    end

`ifdef DECODE_ISSUE_STALL_CNT_EN
    logic [15:0] stall_q;

    // Saturating count of stalled fetch cycles.
    always_ff @(posedge clk_r or negedge reset_n_r) begin
        if (!reset_n_r) begin
            stall_q <= '0;
        end else if (stall_out && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
